// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
// The fetch FSM states, the queued {pc, instr} entry and the NOP value
// presented when nothing has been fetched yet all live here.
package fetch_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: single-outstanding instruction-memory request/response bus.
// The fetch unit is the master (drives req/addr), the memory the slave.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int W = WORD_W
);

    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetched {pc, instr} pairs.
// Entry 0 is always the head. Flush wins over push; push and pop may
// happen in the same cycle, including when the queue is full.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  fetch_entry_t i_pushEntry,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_entry0;
    fetch_entry_t r_entry1;
    logic [1:0]   r_count;
    logic         w_doPop;
    logic         w_doPush;

    // Qualify pop/push so an empty pop or a full push without pop is ignored.
    always_comb begin
        w_doPop  = i_pop && (r_count != 2'd0);
        w_doPush = i_push && ((r_count != 2'd2) || w_doPop);
    end

    // Shift-register FIFO: pops move entry1 into the head slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count  <= 2'd0;
            r_entry0 <= '0;
            r_entry1 <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_doPush, w_doPop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_entry0 <= i_pushEntry;
                    end else begin
                        r_entry1 <= i_pushEntry;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_entry0 <= r_entry1;
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_entry0 <= i_pushEntry;
                    end else begin
                        r_entry0 <= r_entry1;
                        r_entry1 <= i_pushEntry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_entry0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end feeding the F->D register.
// Owns the fetch PC, keeps one memory request outstanding at a time, buffers
// returned words in a 2-entry queue and applies execute-stage redirects,
// discarding responses made stale by a redirect (KILL state).
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- when defined, a redirect
// to a non-word-aligned target raises FetchExcF and halts fetch until the next
// redirect or reset; when undefined the low target bits are forced to zero.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    word_width = WORD_W,
    parameter logic [word_width-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  StallF,
    input  logic                  PCSrcE,
    input  logic [word_width-1:0] PCTargetE,
    fetch_if.master               imem,
    output logic [word_width-1:0] instrF,
    output logic [word_width-1:0] PCF,
    output logic [word_width-1:0] PCPlus4F,
    output logic                  FetchValidF,
    output logic                  FetchExcF
);

    fetch_state_t          r_state;
    logic [word_width-1:0] r_fetchPc;
    logic [word_width-1:0] r_reqPc;
    logic [word_width-1:0] r_excPc;
    logic                  r_exc;

    logic [1:0]            w_count;
    fetch_entry_t          w_head;
    fetch_entry_t          w_pushEntry;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_outstanding;
    logic                  w_slotFree;
    logic                  w_misalign;
    logic                  w_blocked;
    logic                  w_issue;
    logic [2:0]            w_countNext;
    logic [word_width-1:0] w_target;
    logic [word_width-1:0] w_issueAddr;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_target   = PCTargetE;
    assign w_misalign = PCSrcE && (PCTargetE[1:0] != 2'b00);
`else
    assign w_target   = {PCTargetE[word_width-1:2], 2'b00};
    assign w_misalign = 1'b0;
`endif

    assign FetchValidF = (w_count != 2'd0);
    assign FetchExcF   = r_exc;

    // Issue decision: a request may go out when no live request blocks the
    // port and the queue will hold at most one entry at the end of the cycle.
    always_comb begin
        w_outstanding  = (r_state == WAIT) || (r_state == KILL);
        w_slotFree     = (r_state == IDLE) || (w_outstanding && imem.imem_rvalid);
        w_push         = (r_state == WAIT) && imem.imem_rvalid && !PCSrcE;
        w_pop          = FetchValidF && !StallF && !PCSrcE;
        w_countNext    = PCSrcE ? 3'd0
                                : (3'({1'b0, w_count}) + 3'(w_push) - 3'(w_pop));
        w_blocked      = PCSrcE ? w_misalign : r_exc;
        w_issueAddr    = PCSrcE ? w_target : r_fetchPc;
        w_issue        = reset && w_slotFree && !w_blocked && (w_countNext <= 3'd1);
        w_pushEntry    = '{pc: r_reqPc, instr: imem.imem_rdata};
        imem.imem_req  = w_issue;
        imem.imem_addr = w_issue ? w_issueAddr : '0;
    end

    // Request FSM plus fetch/request PC and misaligned-target exception state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_fetchPc <= RESET_PC;
            r_reqPc   <= '0;
            r_exc     <= 1'b0;
            r_excPc   <= '0;
        end else begin
            if (w_issue) begin
                r_state   <= WAIT;
                r_reqPc   <= w_issueAddr;
                r_fetchPc <= w_issueAddr + word_width'(4);
            end else begin
                if (w_outstanding && !imem.imem_rvalid) begin
                    r_state <= PCSrcE ? KILL : r_state;
                end else begin
                    r_state <= IDLE;
                end
                if (PCSrcE) begin
                    r_fetchPc <= w_target;
                end
            end
            if (PCSrcE) begin
                r_exc   <= w_misalign;
                r_excPc <= PCTargetE;
            end
        end
    end

    // Present the queue head, or the empty/exception values when nothing is queued.
    always_comb begin
        instrF   = NOP_INSTR;
        PCF      = '0;
        PCPlus4F = '0;
        if (FetchValidF) begin
            instrF   = w_head.instr;
            PCF      = w_head.pc;
            PCPlus4F = w_head.pc + word_width'(4);
        end else if (r_exc) begin
            PCF = r_excPc;
        end
    end

    fetch_queue u_queue (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pushEntry (w_pushEntry),
        .i_pop       (w_pop),
        .i_flush     (PCSrcE),
        .o_count     (w_count),
        .o_head      (w_head)
    );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end feeding the F→D pipeline register. It owns the fetch PC and issues single-word requests to instruction memory, with one request outstanding at a time. Returned words are buffered with their PC in a 2-entry queue and presented as instrF/PCF/PCPlus4F. It absorbs decode-side stalls and applies execute-stage redirects, discarding any in-flight response made stale by a redirect.

## Interface
- word_width, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low: state clears on any posedge with reset==0
- StallF  in  1  decode not accepting this cycle (hazard unit)
- PCSrcE  in  1  redirect request from execute
- PCTargetE  in  word_width  redirect target
- imem_req  out  1  request valid, one-cycle pulse per request
- imem_addr  out  word_width  request address; 0 when imem_req==0
- imem_rvalid  in  1  response valid; ≥1 cycle after imem_req
- imem_rdata  in  word_width  response word
- instrF  out  word_width  head-of-queue instruction; 32'h0000_0013 (NOP) when empty
- PCF  out  word_width  head PC; 0 when empty
- PCPlus4F  out  word_width  PCF+4, mod 2^32; 0 when empty
- FetchValidF  out  1  queue non-empty
- FetchExcF  out  1  misaligned-target exception (see Configuration)

## Operation
- Consume: FetchValidF && !StallF && !PCSrcE pops the head.
- Request states:
  - IDLE: nothing outstanding.
  - WAIT: live request outstanding.
  - KILL: request outstanding, response to be discarded.
- Issue rule: in IDLE, or in WAIT with imem_rvalid, issue at fetch_pc if end-of-cycle queue occupancy ≤1. On issue: req_pc←fetch_pc, fetch_pc←fetch_pc+4 (wraps), next state WAIT.
- WAIT + imem_rvalid, no redirect: push {req_pc, imem_rdata}. Occupancy can never exceed 2. Push and pop in the same cycle are legal.
- Redirect (PCSrcE=1) has priority over StallF and over push:
  - queue flushed
  - fetch_pc←PCTargetE
  - WAIT without rvalid → KILL
  - WAIT with rvalid → response dropped; request for target issued same cycle → WAIT
  - IDLE → request for target issued same cycle → WAIT
  - KILL → stays KILL, fetch_pc updated
- KILL + imem_rvalid: response dropped. If no new redirect arrives that cycle, request at fetch_pc is issued same cycle → WAIT.
- Reset: state IDLE, queue empty, fetch_pc←RESET_PC, FetchExcF=0, all outputs at their empty values. A request in flight at reset is abandoned; its late rvalid is ignored until the first post-reset issue.

## Timing
- Cycle 0 = first cycle with reset==1: imem_req=1, imem_addr=RESET_PC.
- 1-cycle memory with no stalls: request at t, rvalid at t+1, FetchValidF at t+2. Steady state: one instruction per cycle.
- Redirect at cycle r with no request outstanding: target requested at r, instruction valid at r+2.
- Outputs are registered from queue state. imem_req/imem_addr are combinational from state, queue count and inputs.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with PCTargetE[1:0]≠0 issues no request, flushes the queue, and sets FetchExcF=1 with PCF=PCTargetE.
  - FetchValidF=0; fetch halts until the next redirect or reset, which clears FetchExcF.
  - If this redirect lands in KILL, the stale response is still drained.
- Undefined: PCTargetE[1:0] is treated as 2'b00; FetchExcF is tied 0.

## Structure
- Package fetch_pkg:
  - NOP_INSTR constant (32'h0000_0013)
  - fetch_state_t enum {IDLE, WAIT, KILL}
  - fetch_entry_t struct {pc, instr}
- Sub-module fetch_queue: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, head. Flush has priority over push.
- fetch_unit holds the FSM, fetch_pc, req_pc, issue logic and output registers.

## Test plan
- Reset released, RESET_PC=0x100, 1-cycle memory, StallF=0 → requests 0x100, 0x104, 0x108 on consecutive cycles; FetchValidF from cycle 2 with PCF=0x100, PCPlus4F=0x104.
- StallF held 4 cycles mid-stream → queue fills to 2; imem_req stays 0 while full. After release, PCs continue in order with no gap or duplicate.
- 3-cycle memory latency, PCSrcE=1 to 0x200 one cycle after a request to 0x108 → 0x108 response dropped; next imem_addr=0x200; first valid PCF=0x200.
- PCSrcE coincident with imem_rvalid in WAIT → word dropped; imem_addr=target in the same cycle.
- fetch_pc=0xFFFF_FFFC → next request to 0x0000_0000; PCPlus4F=0 for the head at 0xFFFF_FFFC.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x202 → FetchExcF=1, PCF=0x202, no imem_req. A later redirect to 0x300 clears FetchExcF and fetches 0x300.
